// File: rtl/mealy_bit_feeder_if.sv
// Byte-in / bit-out handshake bundle for mealy_bit_feeder.
// master drives bytes and ser_ready; slave is the feeder.
interface mealy_bit_feeder_if #(
  parameter int FIFO_DEPTH = 2
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          lsb_first;
  logic          ser_bit;
  logic          ser_valid;
  logic          ser_ready;
  logic          frame_start;
  logic          busy;
  logic [CW-1:0] fifo_count;

  modport master (
    output in_data,
    output in_valid,
    output lsb_first,
    output ser_ready,
    input  in_ready,
    input  ser_bit,
    input  ser_valid,
    input  frame_start,
    input  busy,
    input  fifo_count
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  lsb_first,
    input  ser_ready,
    output in_ready,
    output ser_bit,
    output ser_valid,
    output frame_start,
    output busy,
    output fifo_count
  );
endinterface

// File: rtl/mealy_bit_feeder.sv
// Byte FIFO feeding a bit shifter for a Mealy sequence detector.
// Optional FEEDER_PARITY_EN appends an even-parity bit per byte.
module mealy_bit_feeder #(
  parameter int FIFO_DEPTH = 2
) (
  input logic             clk,
  input logic             rst,
  mealy_bit_feeder_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
`ifdef FEEDER_PARITY_EN
    S_PARITY = 2'd2,
`endif
    S_SHIFT  = 2'd1
  } state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          lsb_q, lsb_d;

  logic          push;
  logic          pop;
  logic          xfer;
  logic          fifo_ne;
  logic          load_slot;

  assign fifo_ne      = (cnt_q != '0);
  assign bus.in_ready = (cnt_q < FULL) && !rst;
  assign push         = bus.in_valid && bus.in_ready;
  assign xfer         = (state_q != S_IDLE) && bus.ser_ready;
  assign bus.busy       = fifo_ne || (state_q != S_IDLE);
  assign bus.fifo_count = cnt_q;

  // Shifter state register; reset drops any partial byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      shreg_q <= 8'd0;
      lsb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      lsb_q   <= lsb_d;
    end
  end

  // Next shifter state; a frame end reloads at the same edge.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    lsb_d     = lsb_q;
    load_slot = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        load_slot = 1'b1;
      end
      S_SHIFT: begin
        if (xfer) begin
          if (idx_q == 3'd7) begin
`ifdef FEEDER_PARITY_EN
            state_d = S_PARITY;
            idx_d   = 3'd0;
`else
            load_slot = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef FEEDER_PARITY_EN
      S_PARITY: begin
        if (xfer) begin
          load_slot = 1'b1;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (load_slot) begin
      idx_d = 3'd0;
      if (fifo_ne) begin
        pop     = 1'b1;
        state_d = S_SHIFT;
        shreg_d = mem_q[rptr_q];
        lsb_d   = bus.lsb_first;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // Serial outputs are a pure function of the held shifter state.
  always_comb begin
    bus.ser_valid   = 1'b0;
    bus.ser_bit     = 1'b0;
    bus.frame_start = 1'b0;
    unique case (state_q)
      S_SHIFT: begin
        bus.ser_valid   = 1'b1;
        bus.ser_bit     = lsb_q ? shreg_q[idx_q]
                                : shreg_q[3'd7 - idx_q];
        bus.frame_start = (idx_q == 3'd0);
      end
`ifdef FEEDER_PARITY_EN
      S_PARITY: begin
        bus.ser_valid = 1'b1;
        bus.ser_bit   = ^shreg_q;
      end
`endif
      default: begin
        bus.ser_valid = 1'b0;
      end
    endcase
  end

  // FIFO pointer and occupancy update.
  always_comb begin
    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
    cnt_d  = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO control registers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // FIFO storage; in_ready is low in reset so no write occurs then.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= bus.in_data;
    end
  end

endmodule

// File: tb/tb_mealy_bit_feeder.sv
// Self-checking bench for mealy_bit_feeder.
// Directed scenarios plus randomized traffic against a bit-queue model.
module tb_mealy_bit_feeder;

  localparam int DEPTH = 2;
`ifdef FEEDER_PARITY_EN
  localparam int FB = 9;
`else
  localparam int FB = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  logic [1:0] exp_q [$];

  always #5 clk = ~clk;

  mealy_bit_feeder_if #(.FIFO_DEPTH(DEPTH)) bus ();

  mealy_bit_feeder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model: each accepted byte becomes its frame of {first, bit} entries.
  function automatic void enqueue(input logic [7:0] b, input logic lsb);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({(i == 0), lsb ? b[i] : b[7-i]});
    end
`ifdef FEEDER_PARITY_EN
    exp_q.push_back({1'b0, ^b});
`endif
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (bus.ser_valid !== 1'b0) begin
      fails++; $display("FAIL reset_ser_valid got %b want 0", bus.ser_valid);
    end
    tests++;
    if (bus.ser_bit !== 1'b0) begin
      fails++; $display("FAIL reset_ser_bit got %b want 0", bus.ser_bit);
    end
    tests++;
    if (bus.frame_start !== 1'b0) begin
      fails++; $display("FAIL reset_frame_start got %b want 0", bus.frame_start);
    end
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++; $display("FAIL reset_busy got %b want 0", bus.busy);
    end
    tests++;
    if (bus.fifo_count !== '0) begin
      fails++; $display("FAIL reset_fifo_count got %0d want 0", bus.fifo_count);
    end
    tests++;
    if (bus.in_ready !== 1'b0) begin
      fails++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_single_frame(input logic lsb, input logic [7:0] seq);
    logic [7:0] b;
    logic       want;
    b = 8'hB4;
    @(posedge clk); #1;
    bus.lsb_first = lsb;
    bus.ser_ready = 1'b1;
    bus.in_data   = b;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.ser_valid !== 1'b0) begin
      fails++; $display("FAIL frame_early_valid lsb=%b got %b want 0", lsb, bus.ser_valid);
    end
    for (int i = 0; i < FB; i++) begin
      @(negedge clk);
      want = (i < 8) ? seq[7-i] : ^b;
      tests++;
      if (bus.ser_valid !== 1'b1 || bus.ser_bit !== want ||
          bus.frame_start !== (i == 0)) begin
        fails++;
        $display("FAIL frame_bit lsb=%b i=%0d got v=%b b=%b fs=%b want v=1 b=%b fs=%b",
                 lsb, i, bus.ser_valid, bus.ser_bit, bus.frame_start, want, (i == 0));
      end
    end
    @(negedge clk);
    tests++;
    if (bus.ser_valid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL frame_end lsb=%b got v=%b busy=%b want 0 0", lsb, bus.ser_valid, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] e;
    exp_q.delete();
    @(posedge clk); #1;
    bus.lsb_first = 1'b0;
    bus.ser_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h01;
    enqueue(8'h01, 1'b0);
    @(posedge clk); #1;
    bus.in_data = 8'h80;
    enqueue(8'h80, 1'b0);
    @(posedge clk); #1;
    bus.in_data = 8'hFF;
    enqueue(8'hFF, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.fifo_count !== 2'd2) begin
      fails++; $display("FAIL b2b_fifo_count got %0d want 2", bus.fifo_count);
    end
    tests++;
    if (bus.in_ready !== 1'b0) begin
      fails++; $display("FAIL b2b_in_ready got %b want 0", bus.in_ready);
    end
    bus.ser_ready = 1'b1;
    for (int i = 0; i < 3 * FB; i++) begin
      e = exp_q.pop_front();
      tests++;
      if (bus.ser_valid !== 1'b1 || bus.ser_bit !== e[0] ||
          bus.frame_start !== e[1]) begin
        fails++;
        $display("FAIL b2b_bit i=%0d got v=%b b=%b fs=%b want v=1 b=%b fs=%b",
                 i, bus.ser_valid, bus.ser_bit, bus.frame_start, e[0], e[1]);
      end
      @(negedge clk);
    end
    tests++;
    if (bus.ser_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_tail_valid got %b want 0", bus.ser_valid);
    end
  endtask

  task automatic test_stall();
    logic [7:0] b;
    logic       got [$];
    logic       pv, pr, pb, pf;
    logic       want;
    int         cyc;
    b  = 8'hB4;
    pv = 1'b0; pr = 1'b0; pb = 1'b0; pf = 1'b0;
    @(posedge clk); #1;
    bus.lsb_first = 1'b0;
    bus.ser_ready = 1'b0;
    bus.in_data   = b;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cyc = 0;
    while (got.size() < FB && cyc < 80) begin
      @(negedge clk);
      bus.ser_ready = ~bus.ser_ready;
      if (pv && !pr) begin
        tests++;
        if (bus.ser_valid !== 1'b1 || bus.ser_bit !== pb ||
            bus.frame_start !== pf) begin
          fails++;
          $display("FAIL stall_hold cyc=%0d got v=%b b=%b fs=%b want v=1 b=%b fs=%b",
                   cyc, bus.ser_valid, bus.ser_bit, bus.frame_start, pb, pf);
        end
      end
      if (bus.ser_valid && bus.ser_ready) got.push_back(bus.ser_bit);
      pv = bus.ser_valid; pr = bus.ser_ready;
      pb = bus.ser_bit;   pf = bus.frame_start;
      cyc++;
    end
    tests++;
    if (got.size() != FB) begin
      fails++; $display("FAIL stall_timeout got %0d bits want %0d", got.size(), FB);
    end else begin
      for (int i = 0; i < FB; i++) begin
        want = (i < 8) ? b[7-i] : ^b;
        tests++;
        if (got[i] !== want) begin
          fails++; $display("FAIL stall_bit i=%0d got %b want %b", i, got[i], want);
        end
      end
    end
    @(posedge clk); #1;
    bus.ser_ready = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bus.lsb_first = 1'b0;
    bus.ser_ready = 1'b1;
    bus.in_data   = 8'hB4;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_data = 8'h55;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (bus.ser_valid !== 1'b1 || bus.ser_bit !== 1'b1 ||
        bus.fifo_count !== 2'd1) begin
      fails++;
      $display("FAIL mid_pre got v=%b b=%b cnt=%0d want 1 1 1",
               bus.ser_valid, bus.ser_bit, bus.fifo_count);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (bus.ser_valid !== 1'b0 || bus.fifo_count !== '0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset got v=%b cnt=%0d busy=%b want 0 0 0",
               bus.ser_valid, bus.fifo_count, bus.busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests++;
      if (bus.ser_valid !== 1'b0) begin
        fails++; $display("FAIL mid_residual cyc=%0d got v=%b want 0", i, bus.ser_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] bytes [$];
    logic [1:0] e;
    logic       lsb;
    int         nb, sent, cyc;
    bit         done;
    for (int burst = 0; burst < 25; burst++) begin
      exp_q.delete();
      bytes.delete();
      lsb  = 1'($urandom % 2);
      nb   = $urandom_range(1, 6);
      for (int j = 0; j < nb; j++) bytes.push_back(8'($urandom));
      sent = 0;
      cyc  = 0;
      done = 1'b0;
      @(posedge clk); #1;
      bus.lsb_first = lsb;
      while (!done && cyc < 1000) begin
        bus.in_valid  = (sent < nb) && ($urandom % 2 == 0);
        bus.in_data   = (sent < nb) ? bytes[sent] : 8'h00;
        bus.ser_ready = ($urandom % 4) != 0;
        @(negedge clk);
        tests++;
        if (bus.fifo_count > DEPTH) begin
          fails++; $display("FAIL rnd_count got %0d want <= %0d", bus.fifo_count, DEPTH);
        end
        if (bus.in_valid && bus.in_ready) begin
          enqueue(bytes[sent], lsb);
          sent++;
        end
        if (bus.ser_valid && bus.ser_ready) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++; $display("FAIL rnd_extra_bit got b=%b want none", bus.ser_bit);
          end else begin
            e = exp_q.pop_front();
            if (bus.ser_bit !== e[0] || bus.frame_start !== e[1]) begin
              fails++;
              $display("FAIL rnd_bit burst=%0d got b=%b fs=%b want b=%b fs=%b",
                       burst, bus.ser_bit, bus.frame_start, e[0], e[1]);
            end
          end
        end
        if (sent == nb && exp_q.size() == 0) done = 1'b1;
        @(posedge clk); #1;
        cyc++;
      end
      bus.in_valid  = 1'b0;
      bus.ser_ready = 1'b0;
      tests++;
      if (!done) begin
        fails++;
        $display("FAIL rnd_timeout burst=%0d got sent=%0d left=%0d want all", burst, sent, exp_q.size());
      end
      @(negedge clk);
      tests++;
      if (bus.busy !== 1'b0) begin
        fails++; $display("FAIL rnd_drain burst=%0d got busy=%b want 0", burst, bus.busy);
      end
    end
  endtask

  initial begin
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.lsb_first = 1'b0;
    bus.ser_ready = 1'b0;
    test_reset();
    test_single_frame(1'b0, 8'hB4);
    test_single_frame(1'b1, 8'h2D);
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
